// File: rtl/arid_tracker_if.sv
// rtl/arid_tracker_if.sv - AR issue, R beat and completion signals of the ARID tracker
interface arid_tracker_if #(
  parameter int ARID_WIDTH    = 3,
  parameter int RID_WIDTH     = 3,
  parameter int RRESP_WIDTH   = 2,
  parameter int SUB_TXN_WIDTH = 3
);
  logic [ARID_WIDTH-1:0]    arid;
  logic [SUB_TXN_WIDTH-1:0] total_sub_txn;
  logic                     m_ar_handshake;
  logic                     ar_full;
  logic                     s_r_handshake;
  logic                     s_rlast;
  logic [RID_WIDTH-1:0]     s_rid;
  logic [RRESP_WIDTH-1:0]   s_rresp;
  logic                     m_rlast;
  logic                     txn_done;
  logic [ARID_WIDTH-1:0]    txn_id;
  logic [RRESP_WIDTH-1:0]   txn_resp;
  logic                     err_unexpected;

  modport master (
    output arid, total_sub_txn, m_ar_handshake,
    output s_r_handshake, s_rlast, s_rid, s_rresp,
    input  ar_full, m_rlast, txn_done, txn_id, txn_resp, err_unexpected
  );

  modport slave (
    input  arid, total_sub_txn, m_ar_handshake,
    input  s_r_handshake, s_rlast, s_rid, s_rresp,
    output ar_full, m_rlast, txn_done, txn_id, txn_resp, err_unexpected
  );
endinterface

// File: rtl/arid_tracker.sv
// rtl/arid_tracker.sv - per-ARID sub-burst tracker regenerating master RLAST and completion
// Define ARID_TRACKER_RESP_MERGE_EN to merge worst-case RRESP over all beats of a transaction.
module arid_tracker #(
  parameter int ARID_WIDTH    = 3,
  parameter int RID_WIDTH     = 3,
  parameter int RRESP_WIDTH   = 2,
  parameter int SUB_TXN_WIDTH = 3,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic          aclk,
  input  logic          arst,
  arid_tracker_if.slave bus
);
  localparam int NUM_ID = 1 << ARID_WIDTH;
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int OCC_W  = PTR_W + 1;

  logic [SUB_TXN_WIDTH-1:0] cnt_mem  [NUM_ID][QUEUE_DEPTH];
  logic [PTR_W-1:0]         wr_ptr   [NUM_ID];
  logic [PTR_W-1:0]         rd_ptr   [NUM_ID];
  logic [OCC_W-1:0]         occ      [NUM_ID];
  logic [SUB_TXN_WIDTH-1:0] done_cnt [NUM_ID];
`ifdef ARID_TRACKER_RESP_MERGE_EN
  logic [RRESP_WIDTH-1:0]   acc      [NUM_ID];
`endif

  logic                     full_sel;
  logic                     push;
  logic                     push_drop;
  logic [SUB_TXN_WIDTH-1:0] push_cnt;
  logic                     r_empty;
  logic [SUB_TXN_WIDTH-1:0] head_cnt;
  logic [SUB_TXN_WIDTH-1:0] done_inc;
  logic                     sub_end;
  logic                     pop;
  logic                     stray_last;
  logic [RRESP_WIDTH-1:0]   merged;
  logic [NUM_ID-1:0]        push_sel;
  logic [NUM_ID-1:0]        pop_sel;
  logic [NUM_ID-1:0]        adv_sel;
  logic [NUM_ID-1:0]        beat_sel;

  logic                     txn_done_q;
  logic [ARID_WIDTH-1:0]    txn_id_q;
  logic [RRESP_WIDTH-1:0]   txn_resp_q;
  logic                     err_q;

  always_comb begin
    full_sel   = (occ[bus.arid] == OCC_W'(QUEUE_DEPTH));
    push       = bus.m_ar_handshake && !full_sel;
    push_drop  = bus.m_ar_handshake && full_sel;
    // A zero count still describes one sub-burst.
    push_cnt   = (bus.total_sub_txn == '0) ? SUB_TXN_WIDTH'(1) : bus.total_sub_txn;
    r_empty    = (occ[bus.s_rid] == '0);
    head_cnt   = cnt_mem[bus.s_rid][rd_ptr[bus.s_rid]];
    done_inc   = done_cnt[bus.s_rid] + SUB_TXN_WIDTH'(1);
    sub_end    = bus.s_r_handshake && bus.s_rlast && !r_empty;
    pop        = sub_end && (done_inc == head_cnt);
    stray_last = bus.s_r_handshake && bus.s_rlast && r_empty;
`ifdef ARID_TRACKER_RESP_MERGE_EN
    merged     = (bus.s_rresp > acc[bus.s_rid]) ? bus.s_rresp : acc[bus.s_rid];
`else
    merged     = bus.s_rresp;
`endif
    push_sel = '0;
    pop_sel  = '0;
    adv_sel  = '0;
    beat_sel = '0;
    if (push)              push_sel[bus.arid] = 1'b1;
    if (pop)               pop_sel[bus.s_rid] = 1'b1;
    if (sub_end && !pop)   adv_sel[bus.s_rid] = 1'b1;
    if (bus.s_r_handshake && !stray_last) beat_sel[bus.s_rid] = 1'b1;
  end

  assign bus.ar_full        = full_sel;
  assign bus.m_rlast        = pop || stray_last;
  assign bus.txn_done       = txn_done_q;
  assign bus.txn_id         = txn_id_q;
  assign bus.txn_resp       = txn_resp_q;
  assign bus.err_unexpected = err_q;

  always_ff @(posedge aclk) begin
    if (push) cnt_mem[bus.arid][wr_ptr[bus.arid]] <= push_cnt;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NUM_ID; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        occ[i]      <= '0;
        done_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ID; i++) begin
        if (push_sel[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_sel[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        // Same-cycle push and pop on one ID leaves occupancy unchanged.
        if (push_sel[i] && !pop_sel[i])      occ[i] <= occ[i] + 1'b1;
        else if (pop_sel[i] && !push_sel[i]) occ[i] <= occ[i] - 1'b1;
        if (pop_sel[i])      done_cnt[i] <= '0;
        else if (adv_sel[i]) done_cnt[i] <= done_cnt[i] + 1'b1;
      end
    end
  end

`ifdef ARID_TRACKER_RESP_MERGE_EN
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NUM_ID; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ID; i++) begin
        if (pop_sel[i])       acc[i] <= '0;
        else if (beat_sel[i]) acc[i] <= merged;
      end
    end
  end
`else
  logic beat_any;
  assign beat_any = |beat_sel;
  logic unused_beat;
  assign unused_beat = beat_any;
`endif

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      txn_done_q <= 1'b0;
      txn_id_q   <= '0;
      txn_resp_q <= '0;
      err_q      <= 1'b0;
    end else begin
      txn_done_q <= pop;
      if (pop) begin
        txn_id_q   <= ARID_WIDTH'(bus.s_rid);
        txn_resp_q <= merged;
      end
      if (push_drop || stray_last) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_arid_tracker.sv
// tb/tb_arid_tracker.sv - directed self-checking bench for arid_tracker
module tb_arid_tracker;
  logic aclk;
  logic arst;
  int   checks = 0;
  int   errors = 0;

`ifdef ARID_TRACKER_RESP_MERGE_EN
  localparam int EXP_MERGED = 2;
`else
  localparam int EXP_MERGED = 0;
`endif

  arid_tracker_if #(.ARID_WIDTH(3), .RID_WIDTH(3), .RRESP_WIDTH(2), .SUB_TXN_WIDTH(3)) bus ();

  arid_tracker #(
    .ARID_WIDTH(3), .RID_WIDTH(3), .RRESP_WIDTH(2), .SUB_TXN_WIDTH(3), .QUEUE_DEPTH(4)
  ) dut (
    .aclk(aclk),
    .arst(arst),
    .bus (bus)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.m_ar_handshake = 1'b0;
    bus.s_r_handshake  = 1'b0;
    bus.s_rlast        = 1'b0;
  endtask

  task automatic push(input int id, input int cnt);
    @(negedge aclk);
    bus.arid           = 3'(id);
    bus.total_sub_txn  = 3'(cnt);
    bus.m_ar_handshake = 1'b1;
    @(posedge aclk);
    #1 idle();
  endtask

  task automatic rbeat(input string tag, input int id, input int resp, input bit last,
                       input bit exp_mrl, input bit exp_done, input int exp_resp);
    @(negedge aclk);
    bus.s_rid         = 3'(id);
    bus.s_rresp       = 2'(resp);
    bus.s_rlast       = last;
    bus.s_r_handshake = 1'b1;
    #1 check({tag, ".m_rlast"}, 32'(bus.m_rlast), 32'(exp_mrl));
    @(posedge aclk);
    #1 idle();
    check({tag, ".txn_done"}, 32'(bus.txn_done), 32'(exp_done));
    if (exp_done) begin
      check({tag, ".txn_id"}, 32'(bus.txn_id), 32'(id));
      check({tag, ".txn_resp"}, 32'(bus.txn_resp), 32'(exp_resp));
    end
  endtask

  task automatic full_at(input string tag, input int id, input bit exp);
    @(negedge aclk);
    bus.arid = 3'(id);
    #1 check(tag, 32'(bus.ar_full), 32'(exp));
  endtask

  task automatic pulse_reset();
    @(negedge aclk);
    arst = 1'b1;
    @(negedge aclk);
    arst = 1'b0;
  endtask

  initial begin
    arst              = 1'b1;
    bus.arid          = '0;
    bus.total_sub_txn = '0;
    bus.s_rid         = '0;
    bus.s_rresp       = '0;
    idle();
    #2;
    check("rst.txn_done", 32'(bus.txn_done), 0);
    check("rst.txn_id", 32'(bus.txn_id), 0);
    check("rst.txn_resp", 32'(bus.txn_resp), 0);
    check("rst.err", 32'(bus.err_unexpected), 0);
    check("rst.ar_full", 32'(bus.ar_full), 0);
    check("rst.m_rlast", 32'(bus.m_rlast), 0);
    @(negedge aclk);
    arst = 1'b0;

    // Single transaction split in three sub-bursts
    push(1, 3);
    rbeat("t1.b0", 1, 0, 0, 0, 0, 0);
    rbeat("t1.l1", 1, 0, 1, 0, 0, 0);
    rbeat("t1.l2", 1, 0, 1, 0, 0, 0);
    rbeat("t1.l3", 1, 0, 1, 1, 1, 0);

    // Interleaved IDs, completion order ID1, ID2, ID1
    push(1, 3);
    push(2, 2);
    push(1, 5);
    rbeat("t2.r2a", 2, 0, 1, 0, 0, 0);
    rbeat("t2.r1a", 1, 0, 1, 0, 0, 0);
    rbeat("t2.r1b", 1, 0, 1, 0, 0, 0);
    rbeat("t2.r1c", 1, 0, 1, 1, 1, 0);
    rbeat("t2.r2b", 2, 0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) rbeat($sformatf("t2.r1n%0d", i), 1, 0, 1, 0, 0, 0);
    rbeat("t2.r1last", 1, 0, 1, 1, 1, 0);

    // Response merging across sub-bursts
    push(3, 2);
    rbeat("t3.b0", 3, 0, 0, 0, 0, 0);
    rbeat("t3.l1", 3, 2, 1, 0, 0, 0);
    rbeat("t3.l2", 3, 0, 1, 1, 1, EXP_MERGED);

    // Full queue, dropped push, same-cycle push and pop
    check("t4.err_before", 32'(bus.err_unexpected), 0);
    push(0, 1);
    push(0, 0);
    push(0, 1);
    push(0, 1);
    full_at("t4.full_id0", 0, 1);
    full_at("t4.full_id1", 1, 0);
    push(0, 3);
    check("t4.err_drop", 32'(bus.err_unexpected), 1);
    rbeat("t4.pop0", 0, 1, 1, 1, 1, 1);
    full_at("t4.relieved", 0, 0);
    @(negedge aclk);
    bus.arid           = 3'd0;
    bus.total_sub_txn  = 3'd1;
    bus.m_ar_handshake = 1'b1;
    bus.s_rid          = 3'd0;
    bus.s_rresp        = 2'd3;
    bus.s_rlast        = 1'b1;
    bus.s_r_handshake  = 1'b1;
    #1 check("t4.pp.m_rlast", 32'(bus.m_rlast), 1);
    @(posedge aclk);
    #1 idle();
    check("t4.pp.txn_done", 32'(bus.txn_done), 1);
    check("t4.pp.txn_resp", 32'(bus.txn_resp), 3);
    full_at("t4.pp.not_full", 0, 0);
    push(0, 1);
    full_at("t4.pp.full", 0, 1);
    for (int i = 0; i < 4; i++) rbeat($sformatf("t4.drain%0d", i), 0, 0, 1, 1, 1, 0);
    full_at("t4.empty", 0, 0);

    // Stray R-last on an empty queue
    pulse_reset();
    check("t5.err_cleared", 32'(bus.err_unexpected), 0);
    rbeat("t5.stray", 5, 0, 1, 1, 0, 0);
    check("t5.err_set", 32'(bus.err_unexpected), 1);
    push(5, 1);
    rbeat("t5.after", 5, 1, 1, 1, 1, 1);

    // Reset in the middle of a transaction
    push(1, 3);
    rbeat("t6.l1", 1, 0, 1, 0, 0, 0);
    rbeat("t6.l2", 1, 0, 1, 0, 0, 0);
    #2 arst = 1'b1;
    #1;
    check("t6.rst.txn_done", 32'(bus.txn_done), 0);
    check("t6.rst.txn_id", 32'(bus.txn_id), 0);
    check("t6.rst.txn_resp", 32'(bus.txn_resp), 0);
    check("t6.rst.err", 32'(bus.err_unexpected), 0);
    check("t6.rst.m_rlast", 32'(bus.m_rlast), 0);
    @(negedge aclk);
    arst = 1'b0;
    push(1, 1);
    rbeat("t6.new", 1, 0, 1, 1, 1, 0);
    rbeat("t6.quiet", 2, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
